// File: rtl/mem_arb_pkg.sv
// Purpose: shared types and defaults for the icache/dcache memory arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mem_arb_pkg;

    localparam int ADDR_W_DEF  = 6;
    localparam int BLOCK_W_DEF = 128;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } arb_state_t;

    typedef enum logic {
        OWNER_I = 1'b0,
        OWNER_D = 1'b1
    } owner_t;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } op_t;

endpackage

// File: rtl/arb_rr2.sv
// Purpose: 2-way round-robin picker between icache and dcache requests.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to sample the grant.
//
// Ports:
//   req_i, req_d  - icache / dcache request
//   last_grant    - owner of the most recently completed transaction
//   grant_valid   - at least one request is pending
//   grant_owner   - selected requester (meaningful when grant_valid)
module arb_rr2
    import mem_arb_pkg::*;
(
    input  logic   req_i,
    input  logic   req_d,
    input  owner_t last_grant,
    output logic   grant_valid,
    output owner_t grant_owner
);

    always_comb begin
        grant_valid = req_i | req_d;
        grant_owner = OWNER_I;
        if (req_i && req_d) begin
            // Contention: whoever was served last yields.
            grant_owner = (last_grant == OWNER_I) ? OWNER_D : OWNER_I;
        end else if (req_d) begin
            grant_owner = OWNER_D;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Purpose: shares one block memory between icache (reads) and dcache (reads and write-backs).
// Latency: 2 cycles + memory busywait cycles from request sample to DONE.
// Backpressure: per-cache busywait stays high until its own transaction reaches DONE.
//
// Ports:
//   clock, reset                    - clock, async active-low reset
//   i_read/i_address                - icache block-read request
//   i_readdata/i_busywait           - block returned to icache, icache stall
//   d_read/d_write/d_address/
//   d_writedata                     - dcache refill / write-back request
//   d_readdata/d_busywait           - block returned to dcache, dcache stall
//   mem_read/mem_write/mem_address/
//   mem_writedata                   - registered memory command
//   mem_readdata/mem_busywait       - memory response
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int BLOCK_W = BLOCK_W_DEF
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               i_read,
    input  logic [ADDR_W-1:0]  i_address,
    output logic [BLOCK_W-1:0] i_readdata,
    output logic               i_busywait,
    input  logic               d_read,
    input  logic               d_write,
    input  logic [ADDR_W-1:0]  d_address,
    input  logic [BLOCK_W-1:0] d_writedata,
    output logic [BLOCK_W-1:0] d_readdata,
    output logic               d_busywait,
    output logic               mem_read,
    output logic               mem_write,
    output logic [ADDR_W-1:0]  mem_address,
    output logic [BLOCK_W-1:0] mem_writedata,
    input  logic [BLOCK_W-1:0] mem_readdata,
    input  logic               mem_busywait
);

    arb_state_t        state_q;
    arb_state_t        state_d;
    owner_t            owner_q;
    owner_t            last_grant_q;
    owner_t            grant_owner;
    op_t               op_q;
    op_t               grant_op;
    logic              grant_valid;
    logic [ADDR_W-1:0] grant_addr;
    logic              mem_done;

    arb_rr2 u_rr (
        .req_i       (i_read),
        .req_d       (d_read | d_write),
        .last_grant  (last_grant_q),
        .grant_valid (grant_valid),
        .grant_owner (grant_owner)
    );

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (grant_valid) state_d = ISSUE;
            // One cycle for the memory to see the strobe and raise busywait.
            ISSUE:   state_d = WAIT;
            WAIT:    if (!mem_busywait) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Combinational outputs and grant mux
    always_comb begin
        i_busywait = i_read & ~((state_q == DONE) && (owner_q == OWNER_I));
        d_busywait = (d_read | d_write) & ~((state_q == DONE) && (owner_q == OWNER_D));
        mem_done   = (state_q == WAIT) && !mem_busywait;
        grant_op   = OP_READ;
        grant_addr = i_address;
        if (grant_owner == OWNER_D) begin
            grant_addr = d_address;
            // A write-back wins over a simultaneous refill; the refill is dropped.
            grant_op   = d_write ? OP_WRITE : OP_READ;
        end
    end

    // Command latches and returned-block registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            owner_q       <= OWNER_I;
            op_q          <= OP_READ;
            last_grant_q  <= OWNER_I;
            mem_read      <= 1'b0;
            mem_write     <= 1'b0;
            mem_address   <= '0;
            mem_writedata <= '0;
            i_readdata    <= '0;
            d_readdata    <= '0;
        end else begin
            if ((state_q == IDLE) && grant_valid) begin
                // Latched copies make later address/data changes by the owner harmless.
                owner_q     <= grant_owner;
                op_q        <= grant_op;
                mem_address <= grant_addr;
                mem_read    <= (grant_op == OP_READ);
                mem_write   <= (grant_op == OP_WRITE);
                if (grant_op == OP_WRITE) begin
                    mem_writedata <= d_writedata;
                end
            end
            if (mem_done) begin
                mem_read     <= 1'b0;
                mem_write    <= 1'b0;
                last_grant_q <= owner_q;
                if (op_q == OP_READ) begin
                    if (owner_q == OWNER_I) begin
                        i_readdata <= mem_readdata;
                    end else begin
                        d_readdata <= mem_readdata;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

    localparam int ADDR_W  = 6;
    localparam int BLOCK_W = 128;

    logic               clock;
    logic               reset;
    logic               i_read;
    logic [ADDR_W-1:0]  i_address;
    logic [BLOCK_W-1:0] i_readdata;
    logic               i_busywait;
    logic               d_read;
    logic               d_write;
    logic [ADDR_W-1:0]  d_address;
    logic [BLOCK_W-1:0] d_writedata;
    logic [BLOCK_W-1:0] d_readdata;
    logic               d_busywait;
    logic               mem_read;
    logic               mem_write;
    logic [ADDR_W-1:0]  mem_address;
    logic [BLOCK_W-1:0] mem_writedata;
    logic [BLOCK_W-1:0] mem_readdata;
    logic               mem_busywait;

    int checks = 0;
    int errors = 0;

    mem_arbiter #(.ADDR_W(ADDR_W), .BLOCK_W(BLOCK_W)) dut (
        .clock         (clock),
        .reset         (reset),
        .i_read        (i_read),
        .i_address     (i_address),
        .i_readdata    (i_readdata),
        .i_busywait    (i_busywait),
        .d_read        (d_read),
        .d_write       (d_write),
        .d_address     (d_address),
        .d_writedata   (d_writedata),
        .d_readdata    (d_readdata),
        .d_busywait    (d_busywait),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .mem_address   (mem_address),
        .mem_writedata (mem_writedata),
        .mem_readdata  (mem_readdata),
        .mem_busywait  (mem_busywait)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Default contents of an unwritten memory block.
    function automatic logic [BLOCK_W-1:0] blk(input logic [ADDR_W-1:0] a);
        logic [31:0] w;
        w = {26'h2B5A5C3, a};
        return {4{w}};
    endfunction

    // Memory model: busywait high for 5 cycles after a strobe, then the op completes.
    logic [BLOCK_W-1:0] wr_mem [64];
    logic [63:0]        written;
    int                 mcnt;
    logic               served;

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            mem_busywait <= 1'b0;
            mem_readdata <= '0;
            mcnt         <= 0;
            served       <= 1'b0;
            written      <= '0;
        end else if (mem_busywait) begin
            if (mcnt == 4) begin
                mem_busywait <= 1'b0;
                served       <= 1'b1;
                if (mem_write) begin
                    wr_mem[mem_address]  <= mem_writedata;
                    written[mem_address] <= 1'b1;
                end else if (mem_read) begin
                    mem_readdata <= written[mem_address] ? wr_mem[mem_address] : blk(mem_address);
                end
            end else begin
                mcnt <= mcnt + 1;
            end
        end else if ((mem_read || mem_write) && !served) begin
            mem_busywait <= 1'b1;
            mcnt         <= 0;
        end else if (!(mem_read || mem_write)) begin
            served <= 1'b0;
        end
    end

    task automatic test_reset();
        reset = 1'b0; i_read = 1'b1; i_address = '0;
        d_read = 1'b0; d_write = 1'b0; d_address = '0; d_writedata = '0;
        #12;
        checks++;
        if (i_busywait !== 1'b1 || d_busywait !== 1'b0) begin
            errors++; $display("FAIL reset_busywait: i=%b d=%b expected i=1 d=0", i_busywait, d_busywait);
        end
        checks++;
        if (mem_read !== 1'b0 || mem_write !== 1'b0 || mem_address !== '0 || mem_writedata !== '0) begin
            errors++; $display("FAIL reset_mem: rd=%b wr=%b addr=%h expected 0 0 00", mem_read, mem_write, mem_address);
        end
        checks++;
        if (i_readdata !== '0 || d_readdata !== '0) begin
            errors++; $display("FAIL reset_readdata: i=%h d=%h expected 0", i_readdata, d_readdata);
        end
        i_read = 1'b0;
        #1;
        checks++;
        if (i_busywait !== 1'b0) begin
            errors++; $display("FAIL reset_busy_follow: got %b expected 0", i_busywait);
        end
        @(negedge clock) reset = 1'b1;
        // Abort a transaction in flight.
        @(negedge clock) begin i_read = 1'b1; i_address = 6'h33; end
        repeat (3) @(negedge clock);
        checks++;
        if (mem_read !== 1'b1 || mem_address !== 6'h33) begin
            errors++; $display("FAIL midrun_pre: rd=%b addr=%h expected 1 33", mem_read, mem_address);
        end
        #2 reset = 1'b0;
        #1;
        checks++;
        if (mem_read !== 1'b0 || mem_address !== '0) begin
            errors++; $display("FAIL midrun_reset: rd=%b addr=%h expected 0 00", mem_read, mem_address);
        end
        i_read = 1'b0;
        @(negedge clock) reset = 1'b1;
        begin
            logic strobe;
            strobe = 1'b0;
            repeat (5) begin
                @(negedge clock);
                if (mem_read || mem_write) strobe = 1'b1;
            end
            checks++;
            if (strobe !== 1'b0) begin
                errors++; $display("FAIL post_reset_strobe: got %b expected 0", strobe);
            end
        end
    endtask

    task automatic test_lone_iread();
        int   lat;
        logic dtog;
        lat = -1; dtog = 1'b0;
        @(negedge clock) begin i_read = 1'b1; i_address = 6'h2A; end
        @(negedge clock);
        checks++;
        if (mem_read !== 1'b1 || mem_write !== 1'b0 || mem_address !== 6'h2A) begin
            errors++; $display("FAIL iread_issue: rd=%b wr=%b addr=%h expected 1 0 2a", mem_read, mem_write, mem_address);
        end
        i_address = 6'h15;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clock);
            if (d_busywait !== 1'b0) dtog = 1'b1;
            if (i_busywait === 1'b0) begin lat = k; break; end
        end
        checks++;
        if (lat != 7) begin
            errors++; $display("FAIL iread_latency: got %0d expected 7", lat);
        end
        checks++;
        if (i_readdata !== blk(6'h2A)) begin
            errors++; $display("FAIL iread_data: got %h expected %h", i_readdata, blk(6'h2A));
        end
        checks++;
        if (mem_address !== 6'h2A) begin
            errors++; $display("FAIL iread_addr_latched: got %h expected 2a", mem_address);
        end
        @(negedge clock);
        checks++;
        if (i_busywait !== 1'b1) begin
            errors++; $display("FAIL iread_one_cycle: got %b expected 1", i_busywait);
        end
        i_read = 1'b0;
        @(negedge clock);
        checks++;
        if (mem_read !== 1'b0 || dtog !== 1'b0) begin
            errors++; $display("FAIL iread_after: rd=%b dtog=%b expected 0 0", mem_read, dtog);
        end
    endtask

    task automatic test_lone_dwrite();
        logic [BLOCK_W-1:0] data;
        logic               rd_seen;
        bit                 ok;
        data = 128'hDEAD_0123_4567_89AB_CDEF_FEDC_BA98_BEEF;
        rd_seen = 1'b0; ok = 0;
        @(negedge clock) begin d_write = 1'b1; d_address = 6'h05; d_writedata = data; end
        @(negedge clock);
        checks++;
        if (mem_write !== 1'b1 || mem_read !== 1'b0 || mem_writedata !== data || mem_address !== 6'h05) begin
            errors++; $display("FAIL dwrite_issue: wr=%b rd=%b addr=%h data=%h", mem_write, mem_read, mem_address, mem_writedata);
        end
        for (int k = 0; k < 40; k++) begin
            @(negedge clock);
            if (mem_read) rd_seen = 1'b1;
            if (d_busywait === 1'b0) begin ok = 1; break; end
        end
        checks++;
        if (!ok) begin
            errors++; $display("FAIL dwrite_timeout: d_busywait stayed %b expected 0", d_busywait);
        end
        checks++;
        if (written[5] !== 1'b1 || wr_mem[5] !== data) begin
            errors++; $display("FAIL dwrite_mem: got %h expected %h", wr_mem[5], data);
        end
        checks++;
        if (rd_seen !== 1'b0) begin
            errors++; $display("FAIL dwrite_no_read: got %b expected 0", rd_seen);
        end
        d_write = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_simultaneous();
        bit ok;
        @(negedge clock) reset = 1'b0;
        @(negedge clock) reset = 1'b1;
        @(negedge clock) begin
            i_read = 1'b1; i_address = 6'h01;
            d_read = 1'b1; d_address = 6'h3F;
        end
        @(negedge clock);
        checks++;
        if (mem_read !== 1'b1 || mem_address !== 6'h3F) begin
            errors++; $display("FAIL sim_first_d: rd=%b addr=%h expected 1 3f", mem_read, mem_address);
        end
        ok = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clock);
            if (d_busywait === 1'b0) begin ok = 1; break; end
        end
        checks++;
        if (!ok || d_readdata !== blk(6'h3F) || i_busywait !== 1'b1) begin
            errors++; $display("FAIL sim_d_done: ok=%0d data=%h ibusy=%b expected %h ibusy=1", ok, d_readdata, i_busywait, blk(6'h3F));
        end
        d_read = 1'b0;
        // Dcache comes straight back while icache is still waiting.
        @(negedge clock) begin d_read = 1'b1; d_address = 6'h20; end
        @(negedge clock);
        checks++;
        if (mem_read !== 1'b1 || mem_address !== 6'h01) begin
            errors++; $display("FAIL sim_second_i: rd=%b addr=%h expected 1 01", mem_read, mem_address);
        end
        ok = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clock);
            if (i_busywait === 1'b0) begin ok = 1; break; end
        end
        checks++;
        if (!ok || i_readdata !== blk(6'h01) || d_busywait !== 1'b1) begin
            errors++; $display("FAIL sim_i_done: ok=%0d data=%h dbusy=%b expected %h dbusy=1", ok, i_readdata, d_busywait, blk(6'h01));
        end
        i_read = 1'b0;
        ok = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clock);
            if (d_busywait === 1'b0) begin ok = 1; break; end
        end
        checks++;
        if (!ok || d_readdata !== blk(6'h20)) begin
            errors++; $display("FAIL sim_d2_done: ok=%0d data=%h expected %h", ok, d_readdata, blk(6'h20));
        end
        d_read = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_rw_both();
        logic [BLOCK_W-1:0] data;
        logic               rd_seen;
        bit                 ok;
        data = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
        rd_seen = 1'b0; ok = 0;
        @(negedge clock) begin d_read = 1'b1; d_write = 1'b1; d_address = 6'h10; d_writedata = data; end
        @(negedge clock);
        checks++;
        if (mem_write !== 1'b1 || mem_read !== 1'b0) begin
            errors++; $display("FAIL rw_issue: wr=%b rd=%b expected 1 0", mem_write, mem_read);
        end
        for (int k = 0; k < 40; k++) begin
            @(negedge clock);
            if (mem_read) rd_seen = 1'b1;
            if (d_busywait === 1'b0) begin ok = 1; break; end
        end
        checks++;
        if (!ok || written[16] !== 1'b1 || wr_mem[16] !== data) begin
            errors++; $display("FAIL rw_mem: ok=%0d got %h expected %h", ok, wr_mem[16], data);
        end
        checks++;
        if (rd_seen !== 1'b0 || d_readdata !== blk(6'h20)) begin
            errors++; $display("FAIL rw_no_read: rd_seen=%b data=%h expected 0 %h", rd_seen, d_readdata, blk(6'h20));
        end
        d_read = 1'b0; d_write = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_withdraw();
        int   rises;
        logic prev;
        bit   ok;
        @(negedge clock) begin i_read = 1'b1; i_address = 6'h07; end
        @(negedge clock);
        checks++;
        if (mem_read !== 1'b1 || mem_address !== 6'h07) begin
            errors++; $display("FAIL wd_issue: rd=%b addr=%h expected 1 07", mem_read, mem_address);
        end
        repeat (3) @(negedge clock);
        i_read = 1'b0;
        #1;
        checks++;
        if (i_busywait !== 1'b0) begin
            errors++; $display("FAIL wd_busy_drop: got %b expected 0", i_busywait);
        end
        rises = 0; prev = mem_read;
        repeat (15) begin
            @(negedge clock);
            if (mem_read && !prev) rises++;
            prev = mem_read;
        end
        checks++;
        if (rises != 0 || mem_read !== 1'b0) begin
            errors++; $display("FAIL wd_no_reissue: rises=%0d rd=%b expected 0 0", rises, mem_read);
        end
        checks++;
        if (i_readdata !== blk(6'h07)) begin
            errors++; $display("FAIL wd_data: got %h expected %h", i_readdata, blk(6'h07));
        end
        @(negedge clock) begin d_read = 1'b1; d_address = 6'h0A; end
        @(negedge clock);
        checks++;
        if (mem_read !== 1'b1 || mem_address !== 6'h0A) begin
            errors++; $display("FAIL wd_d_issue: rd=%b addr=%h expected 1 0a", mem_read, mem_address);
        end
        ok = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clock);
            if (d_busywait === 1'b0) begin ok = 1; break; end
        end
        checks++;
        if (!ok || d_readdata !== blk(6'h0A)) begin
            errors++; $display("FAIL wd_d_done: ok=%0d data=%h expected %h", ok, d_readdata, blk(6'h0A));
        end
        d_read = 1'b0;
        @(negedge clock);
    endtask

    initial begin
        test_reset();
        test_lone_iread();
        test_lone_dwrite();
        test_simultaneous();
        test_rw_both();
        test_withdraw();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
